fir_sequencer: RTL

//  Moore FSM that sequences the 4-tap FIR register-file datapath behind the AHB-lite slave.
//  - Loads the four coefficients when the slave flags a new set.
//  - On each new sample: shifts the sample window, then runs the alternating-sign MAC:
//    R0 = R1*F0 - R2*F1 + R3*F2 - R4*F3.
//  - Reports busy (modwait), overflow (err) and coefficient-load progress (set) back to the slave.

---
 rtl/fir_sequencer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/fir_sequencer.sv
// fir_sequencer: Moore FSM driving the 4-tap FIR register-file datapath.
// Define FIR_ERR_CONTINUE_EN to let an overflow flag err but still finish the MAC.
module fir_sequencer #(
    parameter int OP_W    = 3,
    parameter int REG_W   = 4,
    parameter int COEF_R0 = 6
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             data_ready,
    input  logic             new_coefficient_set,
    input  logic             overflow,
    output logic [OP_W-1:0]  op,
    output logic [REG_W-1:0] src1,
    output logic [REG_W-1:0] src2,
    output logic [REG_W-1:0] dest,
    output logic [1:0]       coefficient_num,
    output logic             modwait,
    output logic             err,
    output logic [1:0]       set
);

    localparam logic [OP_W-1:0] OP_NOP   = OP_W'(0);
    localparam logic [OP_W-1:0] OP_COPY  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_LOAD1 = OP_W'(2);
    localparam logic [OP_W-1:0] OP_LOAD2 = OP_W'(3);
    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(4);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(5);
    localparam logic [OP_W-1:0] OP_MUL   = OP_W'(6);

    typedef enum logic [4:0] {
        IDLE, LC0, LC1, LC2, LC3, LCDONE,
        STORE, CP4, CP3, CP2, CP1,
        MUL1, CP0, MUL2, SUB1, MUL3, ADD1, MUL4, SUB2
`ifndef FIR_ERR_CONTINUE_EN
        , EIDLE
`endif
    } state_t;

    state_t state_q, state_d;
    logic   err_q, err_d;
    logic [1:0] lc_idx;

    function automatic logic [REG_W-1:0] r(input int n);
        return REG_W'(n);
    endfunction

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        case (state_q)
`ifndef FIR_ERR_CONTINUE_EN
            EIDLE,
`endif
            IDLE: begin
                if (data_ready)               state_d = STORE;
                else if (new_coefficient_set) state_d = LC0;
            end
            LC0:    state_d = LC1;
            LC1:    state_d = LC2;
            LC2:    state_d = LC3;
            LC3:    state_d = LCDONE;
            LCDONE: state_d = IDLE;
            STORE:  state_d = CP4;
            CP4:    state_d = CP3;
            CP3:    state_d = CP2;
            CP2:    state_d = CP1;
            CP1:    state_d = MUL1;
            MUL1:   state_d = CP0;
            CP0:    state_d = MUL2;
            MUL2:   state_d = SUB1;
            SUB1:   state_d = MUL3;
            MUL3:   state_d = ADD1;
            ADD1:   state_d = MUL4;
            MUL4:   state_d = SUB2;
            SUB2:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Only the accumulate steps can overflow; the flag is don't-care elsewhere.
        if ((state_q == SUB1 || state_q == ADD1 || state_q == SUB2) && overflow) begin
            err_d = 1'b1;
`ifndef FIR_ERR_CONTINUE_EN
            state_d = EIDLE;
`endif
        end
        if (state_d == STORE) err_d = 1'b0;
    end

    assign lc_idx = 2'(state_q - LC0);

    always_comb begin
        op              = OP_NOP;
        src1            = '0;
        src2            = '0;
        dest            = '0;
        coefficient_num = 2'd0;
        modwait         = 1'b1;
        err             = err_q;
        set             = 2'd2;
        case (state_q)
            IDLE: modwait = 1'b0;
`ifndef FIR_ERR_CONTINUE_EN
            EIDLE: modwait = 1'b0;
`endif
            LC0, LC1, LC2, LC3: begin
                op              = OP_LOAD2;
                coefficient_num = lc_idx;
                dest            = r(COEF_R0) + REG_W'(lc_idx);
                set             = 2'd1;
            end
            LCDONE: set = 2'd0;
            STORE: begin op = OP_LOAD1; dest = r(5); end
            CP4:   begin op = OP_COPY; src1 = r(3); dest = r(4); end
            CP3:   begin op = OP_COPY; src1 = r(2); dest = r(3); end
            CP2:   begin op = OP_COPY; src1 = r(1); dest = r(2); end
            CP1:   begin op = OP_COPY; src1 = r(5); dest = r(1); end
            MUL1: begin
                op = OP_MUL; src1 = r(1); src2 = r(COEF_R0); dest = r(10);
            end
            CP0:   begin op = OP_COPY; src1 = r(10); dest = r(0); end
            MUL2: begin
                op = OP_MUL; src1 = r(2); src2 = r(COEF_R0 + 1); dest = r(10);
            end
            MUL3: begin
                op = OP_MUL; src1 = r(3); src2 = r(COEF_R0 + 2); dest = r(10);
            end
            MUL4: begin
                op = OP_MUL; src1 = r(4); src2 = r(COEF_R0 + 3); dest = r(10);
            end
            SUB1, SUB2: begin
                op = OP_SUB; src1 = r(0); src2 = r(10); dest = r(0);
            end
            ADD1: begin
                op = OP_ADD; src1 = r(0); src2 = r(10); dest = r(0);
            end
            default: modwait = 1'b0;
        endcase
    end

endmodule
